ddr_line_master: RTL and testbench
==================================

# ddr_line_master

Single-outstanding AXI4 master that turns 128-bit cache-line read and write requests from the data cache into single-beat AXI transactions toward the DDR controller. It sits directly beneath `top`'s cache and drives the `M_AXI_*` bundle that `top` exports to the board wrapper. The block serialises exactly one transaction at a time, returns read data or write completion as a one-cycle response pulse, and flags any non-OKAY AXI response.

## Interface
- ADDR_W, 27: byte address width, matches the DDR AXI address.
- DATA_W, 128: line and AXI data width in bits. Fixed; WSTRB width is DATA_W/8.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  cache request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_we  in  1  1 = line write, 0 = line read
- req_addr  in  27  byte address; bits [3:0] are ignored and driven as 0 on AXI
- req_wdata  in  128  write line
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  128  read line, valid with resp_valid on reads; holds its last value otherwise
- resp_err  out  1  valid with resp_valid: RRESP/BRESP != 0, or RLAST == 0 on the read beat
- M_AXI_AW*/W*/B*/AR*/R*: full AXI4 master bundle, widths as in `top`: AWADDR/ARADDR 27, AWLEN/ARLEN 8, AWSIZE/ARSIZE 3, AWBURST/ARBURST 2, AWLOCK 1, ARLOCK 2, CACHE 4, PROT 3, QOS 4, WDATA/RDATA 128, WSTRB 16, RESP 2.

## Operation
- Constants: AxLEN=0, AxSIZE=3'b100, AxBURST=2'b01, AxLOCK=0, AxCACHE=4'b0011, AxPROT=0, AxQOS=0, WSTRB=16'hFFFF, WLAST=1.
- Request latch: on req_valid && req_ready, register addr (low 4 bits zeroed), we and wdata. AxADDR and WDATA come from these registers and stay stable while the corresponding VALID is high.
- States:
  - IDLE: req_ready=1. Handshake moves to AR (read) or AW_W (write).
  - AR: ARVALID=1. On ARREADY, go to R.
  - R: RREADY=1. On RVALID, capture RDATA into resp_rdata. Set err = (RRESP!=0) || !RLAST. Go to DONE.
  - AW_W: AWVALID and WVALID rise together. Each drops independently after its own handshake, tracked by aw_done and w_done flags. When both handshakes are complete (including in the same cycle), go to B.
  - B: BREADY=1. On BVALID, set err = (BRESP!=0). Go to DONE.
  - DONE: resp_valid=1 and resp_err=err for exactly this cycle. Return to IDLE.
- Order independence: any ordering of AWREADY and WREADY is legal, including WREADY before AWREADY. No VALID is ever withdrawn before its handshake.
- No dependence of any VALID on a READY. READY signals may be high before VALID.
- Reset low: state←IDLE and all outputs take reset values on the next edge. Any in-flight AXI transaction is abandoned; the DDR controller shares the same reset.

## Timing
- Reset values: req_ready=1 (once in IDLE after reset); resp_valid=0, resp_err=0, resp_rdata=0; all AXI VALID/READY outputs=0; AWADDR/ARADDR=0; WDATA=0.
- Read, zero-wait slave: accept at cycle 0. ARVALID at cycle 1 with ARREADY. RREADY at cycle 2 with RVALID. resp_valid at cycle 3. req_ready high again at cycle 4.
- Write, zero-wait slave: accept at cycle 0. AW/W handshake at cycle 1. BREADY at cycle 2 with BVALID. resp_valid at cycle 3.
- Each cycle of AXI wait adds exactly one cycle of latency.
- Throughput: at most one transaction per 4 cycles.
- req_* inputs are ignored whenever req_ready=0.

## Test plan
- Read, addr 0x0000123, slave ARREADY immediate, RDATA=128'hDEADBEEF_…_0001, RRESP=0, RLAST=1 -> ARADDR=0x0000120, resp_valid at cycle 3, resp_rdata matches, resp_err=0.
- Write, addr 0x7FFFFF0, AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after cycle 1, AWVALID held stable 4 cycles, BREADY only after both handshakes, single resp_valid pulse, resp_err=0.
- Write with WREADY 2 cycles after AWREADY, then BRESP=2'b10 -> no VALID withdrawn early, resp_err=1 with resp_valid.
- Read with RLAST=0 and RRESP=0 -> resp_err=1. Block returns to IDLE and accepts a back-to-back read the next cycle.
- Assert rst=0 while in R with RVALID never arriving -> next edge: RREADY=0, resp_valid=0, req_ready=1 after release; a subsequent read completes normally.
- Hold req_valid high during a busy write -> exactly one transaction issued per accepted handshake, req_ready low throughout AW_W/B/DONE.

Source files
------------

// File: rtl/ddr_line_master_if.sv
// AXI4 master bundle between the cache line master and the DDR controller.
interface ddr_line_master_if #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 128
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Write address channel
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  // Write data channel
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  // Write response channel
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  // Read address channel
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  // Read data channel
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ddr_line_master.sv
// Single-outstanding AXI4 master: one 128-bit cache line per single-beat transaction.
module ddr_line_master #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  ddr_line_master_if.master m_axi
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // Line-aligned addresses: the low nibble never reaches the bus.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              aw_done;
  logic              w_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              awvalid_nxt;
  logic              wvalid_nxt;
  logic              aw_done_nxt;
  logic              w_done_nxt;
  logic              aw_fin;
  logic              w_fin;
  logic              err_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              load;

  // Fixed single-beat, full-width, incrementing transaction attributes.
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = 3'b100;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.wstrb   = {STRB_W{1'b1}};
  assign m_axi.wlast   = 1'b1;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = 3'b100;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 2'b00;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'b0000;

  // Bus payload and handshake outputs come straight from registers.
  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake bookkeeping and response capture.
  always_comb begin
    state_nxt   = state;
    awvalid_nxt = awvalid_q;
    wvalid_nxt  = wvalid_q;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    aw_fin      = 1'b0;
    w_fin       = 1'b0;
    err_nxt     = 1'b0;
    rdata_nxt   = resp_rdata;
    load        = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          load = 1'b1;
          if (req_we) begin
            state_nxt   = AW_W;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
          end else begin
            state_nxt = AR;
          end
        end
      end
      AR: begin
        if (m_axi.arready) begin
          state_nxt = R;
        end
      end
      R: begin
        if (m_axi.rvalid) begin
          rdata_nxt = m_axi.rdata;
          err_nxt   = (m_axi.rresp != 2'b00) || !m_axi.rlast;
          state_nxt = DONE;
        end
      end
      AW_W: begin
        // AW and W complete independently, in either order or together.
        aw_fin      = aw_done || (awvalid_q && m_axi.awready);
        w_fin       = w_done  || (wvalid_q  && m_axi.wready);
        aw_done_nxt = aw_fin;
        w_done_nxt  = w_fin;
        awvalid_nxt = !aw_fin;
        wvalid_nxt  = !w_fin;
        if (aw_fin && w_fin) begin
          state_nxt = B;
        end
      end
      B: begin
        if (m_axi.bvalid) begin
          err_nxt   = (m_axi.bresp != 2'b00);
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs, flags and request latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_ready  <= 1'b1;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      req_ready  <= (state_nxt == IDLE);
      arvalid_q  <= (state_nxt == AR);
      rready_q   <= (state_nxt == R);
      bready_q   <= (state_nxt == B);
      awvalid_q  <= awvalid_nxt;
      wvalid_q   <= wvalid_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
      resp_valid <= (state_nxt == DONE);
      resp_err   <= err_nxt;
      resp_rdata <= rdata_nxt;
      if (load) begin
        addr_q  <= req_addr & LINE_MASK;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ddr_line_master.sv
// Directed bench for ddr_line_master with a scripted AXI slave and response scoreboard.
module tb_ddr_line_master;
  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  ddr_line_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

  ddr_line_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .m_axi      (m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  exp_t sb[$];

  int n_assert   = 0;
  int n_fail     = 0;
  int cyc_n      = 0;
  int ar_cnt     = 0;
  int aw_cnt     = 0;
  int w_cnt      = 0;
  int withdraw_n = 0;
  logic ar_pend  = 1'b0;
  logic aw_pend  = 1'b0;
  logic w_pend   = 1'b0;
  logic [DATA_W-1:0] last_rdata = '0;

  // Cycle counter, handshake counters and early-VALID-withdrawal monitor.
  always @(posedge clk) begin
    cyc_n      <= cyc_n + 1;
    ar_cnt     <= ar_cnt + ((rst && m.arvalid && m.arready) ? 1 : 0);
    aw_cnt     <= aw_cnt + ((rst && m.awvalid && m.awready) ? 1 : 0);
    w_cnt      <= w_cnt  + ((rst && m.wvalid  && m.wready)  ? 1 : 0);
    withdraw_n <= withdraw_n + ((rst && ar_pend && !m.arvalid) ? 1 : 0)
                             + ((rst && aw_pend && !m.awvalid) ? 1 : 0)
                             + ((rst && w_pend  && !m.wvalid)  ? 1 : 0);
    ar_pend    <= rst && m.arvalid && !m.arready;
    aw_pend    <= rst && m.awvalid && !m.awready;
    w_pend     <= rst && m.wvalid  && !m.wready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request from the cache side plus the slave's side of the transaction.
  // Read: d1 = ARREADY delay, d3 = RVALID delay. Write: d1 = AWREADY delay,
  // d2 = WREADY delay, d3 = BVALID delay. hold keeps req_valid high while busy.
  task automatic txn(input logic we, input logic [26:0] addr, input logic [127:0] data,
                     input logic [1:0] resp, input logic last,
                     input int d1, input int d2, input int d3, input logic hold);
    int          c0;
    int          dmax;
    exp_t        e;
    logic [26:0] exp_addr;
    exp_addr = addr & 27'h7FFFFF0;
    e.we    = we;
    e.rdata = we ? last_rdata : data;
    e.err   = we ? (resp != 2'b00) : ((resp != 2'b00) || !last);
    dmax    = 0;
    chk("req_ready_idle", 128'(req_ready), 128'(1'b1));
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = we ? data : {$urandom, $urandom, $urandom, $urandom};
    sb.push_back(e);
    if (!we && d1 == 0) m.arready = 1'b1;
    c0 = cyc_n;
    step();
    if (!hold) req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~req_wdata;
    if (!we) begin
      for (int i = 0; i < 8 && !m.arvalid; i++) step();
      chk("arvalid_rise", 128'(m.arvalid), 128'(1'b1));
      chk("araddr", 128'(m.araddr), 128'(exp_addr));
      for (int k = 0; k <= d1; k++) begin
        m.arready = (k == d1);
        chk("arvalid_hold", 128'(m.arvalid), 128'(1'b1));
        chk("araddr_stable", 128'(m.araddr), 128'(exp_addr));
        chk("req_ready_busy", 128'(req_ready), 128'(1'b0));
        step();
      end
      m.arready = 1'b0;
      for (int i = 0; i < 8 && !m.rready; i++) step();
      chk("rready", 128'(m.rready), 128'(1'b1));
      chk("arvalid_drop", 128'(m.arvalid), 128'(1'b0));
      for (int k = 0; k <= d3; k++) begin
        m.rvalid = (k == d3);
        m.rdata  = data;
        m.rresp  = resp;
        m.rlast  = last;
        chk("rready_hold", 128'(m.rready), 128'(1'b1));
        step();
      end
      m.rvalid = 1'b0;
      m.rlast  = 1'b0;
      m.rdata  = '0;
      m.rresp  = 2'b00;
      dmax     = d1;
    end else begin
      for (int i = 0; i < 8 && !(m.awvalid || m.wvalid); i++) step();
      chk("awvalid_rise", 128'(m.awvalid), 128'(1'b1));
      chk("wvalid_rise", 128'(m.wvalid), 128'(1'b1));
      chk("wdata", m.wdata, data);
      dmax = (d1 > d2) ? d1 : d2;
      for (int k = 0; k <= dmax; k++) begin
        m.awready = (k == d1);
        m.wready  = (k == d2);
        chk("awvalid_hold", 128'(m.awvalid), 128'(k <= d1));
        chk("wvalid_hold", 128'(m.wvalid), 128'(k <= d2));
        chk("awaddr_stable", 128'(m.awaddr), 128'(exp_addr));
        chk("bready_early", 128'(m.bready), 128'(1'b0));
        chk("req_ready_busy", 128'(req_ready), 128'(1'b0));
        step();
      end
      m.awready = 1'b0;
      m.wready  = 1'b0;
      for (int i = 0; i < 8 && !m.bready; i++) step();
      chk("bready", 128'(m.bready), 128'(1'b1));
      for (int k = 0; k <= d3; k++) begin
        m.bvalid = (k == d3);
        m.bresp  = resp;
        chk("bready_hold", 128'(m.bready), 128'(1'b1));
        chk("req_ready_busy_b", 128'(req_ready), 128'(1'b0));
        step();
      end
      m.bvalid = 1'b0;
      m.bresp  = 2'b00;
    end
    for (int i = 0; i < 8 && !resp_valid; i++) step();
    chk("resp_valid", 128'(resp_valid), 128'(1'b1));
    chk("req_ready_done", 128'(req_ready), 128'(1'b0));
    if (hold) req_valid = 1'b0;
    chk("latency", 128'(cyc_n - c0), 128'(3 + dmax + d3));
    chk("sb_nonempty", 128'(sb.size() != 0), 128'(1'b1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("resp_err", 128'(resp_err), 128'(e.err));
    end
    if (!we) last_rdata = data;
    step();
    chk("resp_pulse", 128'(resp_valid), 128'(1'b0));
    chk("req_ready_back", 128'(req_ready), 128'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar0;
    int aw0;
    int w0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    m.awready = 1'b0;
    m.wready  = 1'b0;
    m.bvalid  = 1'b0;
    m.bresp   = 2'b00;
    m.arready = 1'b0;
    m.rvalid  = 1'b0;
    m.rdata   = '0;
    m.rresp   = 2'b00;
    m.rlast   = 1'b0;

    // Reset values.
    rst = 1'b0;
    step();
    step();
    chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
    chk("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
    chk("rst_resp_err", 128'(resp_err), 128'(1'b0));
    chk("rst_resp_rdata", resp_rdata, 128'h0);
    chk("rst_arvalid", 128'(m.arvalid), 128'(1'b0));
    chk("rst_awvalid", 128'(m.awvalid), 128'(1'b0));
    chk("rst_wvalid", 128'(m.wvalid), 128'(1'b0));
    chk("rst_rready", 128'(m.rready), 128'(1'b0));
    chk("rst_bready", 128'(m.bready), 128'(1'b0));
    chk("rst_araddr", 128'(m.araddr), 128'h0);
    chk("rst_awaddr", 128'(m.awaddr), 128'h0);
    chk("rst_wdata", m.wdata, 128'h0);

    // Fixed transaction attributes.
    chk("arlen", 128'(m.arlen), 128'h0);
    chk("arsize", 128'(m.arsize), 128'h4);
    chk("arburst", 128'(m.arburst), 128'h1);
    chk("arcache", 128'(m.arcache), 128'h3);
    chk("arlock", 128'(m.arlock), 128'h0);
    chk("awlen", 128'(m.awlen), 128'h0);
    chk("awsize", 128'(m.awsize), 128'h4);
    chk("awlock", 128'(m.awlock), 128'h0);
    chk("awcache", 128'(m.awcache), 128'h3);
    chk("awqos", 128'(m.awqos), 128'h0);
    chk("wstrb", 128'(m.wstrb), 128'hFFFF);
    chk("wlast", 128'(m.wlast), 128'h1);

    rst = 1'b1;
    step();

    // Zero-wait read, unaligned address.
    txn(1'b0, 27'h0000123, 128'hDEADBEEF_CAFEF00D_12345678_00000001, 2'b00, 1'b1, 0, 0, 0, 1'b0);

    // Write with AWREADY late, WREADY immediate.
    txn(1'b1, 27'h7FFFFF0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2'b00, 1'b1, 3, 0, 0, 1'b0);

    // Write with WREADY after AWREADY, SLVERR response.
    txn(1'b1, 27'h0ABCDE7, 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0, 2'b10, 1'b1, 0, 2, 1, 1'b0);

    // Read with RLAST low, then a back-to-back read with waits.
    txn(1'b0, 27'h1234560, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2'b00, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b0, 27'h0000FFF, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 2'b00, 1'b1, 1, 0, 2, 1'b0);

    // Reset while waiting for RVALID abandons the read.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 27'h0000400;
    m.arready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    m.arready = 1'b0;
    for (int i = 0; i < 8 && !m.rready; i++) step();
    chk("abort_rready", 128'(m.rready), 128'(1'b1));
    step();
    step();
    chk("abort_no_resp", 128'(resp_valid), 128'(1'b0));
    rst = 1'b0;
    step();
    chk("abort_rready_rst", 128'(m.rready), 128'(1'b0));
    chk("abort_resp_valid", 128'(resp_valid), 128'(1'b0));
    chk("abort_arvalid", 128'(m.arvalid), 128'(1'b0));
    chk("abort_rdata_hold", resp_rdata, 128'h0);
    rst = 1'b1;
    last_rdata = '0;
    chk("abort_req_ready", 128'(req_ready), 128'(1'b1));
    step();
    txn(1'b0, 27'h0000408, 128'hFACE_B00C_0000_1111_2222_3333_4444_5555, 2'b00, 1'b1, 0, 0, 0, 1'b0);

    // req_valid held high through a busy write: exactly one transaction.
    ar0 = ar_cnt;
    aw0 = aw_cnt;
    w0  = w_cnt;
    txn(1'b1, 27'h0200010, 128'h0BAD_F00D_0BAD_F00D_1234_5678_9ABC_DEF0, 2'b00, 1'b1, 1, 1, 2, 1'b1);
    step();
    chk("hold_aw_count", 128'(aw_cnt - aw0), 128'(1));
    chk("hold_w_count", 128'(w_cnt - w0), 128'(1));
    chk("hold_ar_count", 128'(ar_cnt - ar0), 128'(0));
    chk("hold_idle", 128'(req_ready), 128'(1'b1));

    // Read with DECERR.
    txn(1'b0, 27'h3000020, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 2'b11, 1'b1, 2, 0, 0, 1'b0);

    chk("no_valid_withdrawn", 128'(withdraw_n), 128'(0));
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
